// File: rtl/lif_pkg.sv
// lif_pkg: shared constants for the leaky integrate-and-fire array.
//   MODE_ZERO / MODE_SUB : sub_mode encodings (reset-to-zero / subtract-threshold)
//   SPIKE_CNT_W          : width of the saturating total-spike counter
package lif_pkg;
  localparam logic MODE_ZERO   = 1'b0;
  localparam logic MODE_SUB    = 1'b1;
  localparam int   SPIKE_CNT_W = 16;
endpackage

// File: rtl/lif_cell.sv
// lif_cell: one leaky integrate-and-fire channel.
// Ports:
//   clk, rst            clock, async active-high reset
//   tick                update strobe
//   cur [W]             input current for this channel
//   thresh [W]          firing threshold (0 disables firing)
//   leak_shift [3]      leak = v >> leak_shift, 0 = no leak
//   refrac [RW]         refractory ticks loaded on a spike
//   sub_mode            MODE_ZERO / MODE_SUB post-spike behaviour
//   v [W]               registered membrane value
//   spike               registered one-cycle spike flag
module lif_cell
  import lif_pkg::*;
#(
  parameter int W  = 8,
  parameter int RW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick,
  input  logic [W-1:0]  cur,
  input  logic [W-1:0]  thresh,
  input  logic [2:0]    leak_shift,
  input  logic [RW-1:0] refrac,
  input  logic          sub_mode,
  output logic [W-1:0]  v,
  output logic          spike
);

  logic [RW-1:0] rcnt;
  logic [W-1:0]  leak;
  logic [W:0]    sum;
  logic [W-1:0]  v_next;
  logic          fire;

  // A shift of zero would remove the whole membrane, so it means "no leak".
  always_comb begin
    leak   = (leak_shift == 3'd0) ? '0 : (v >> leak_shift);
    sum    = {1'b0, v} - {1'b0, leak} + {1'b0, cur};
    v_next = sum[W] ? '1 : sum[W-1:0];
    fire   = (thresh != '0) && (v_next >= thresh);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v     <= '0;
      rcnt  <= '0;
      spike <= 1'b0;
    end else begin
      spike <= 1'b0;
      if (tick) begin
        if (rcnt != '0) begin
          v    <= '0;
          rcnt <= rcnt - 1'b1;
        end else if (fire) begin
          spike <= 1'b1;
          v     <= (sub_mode == MODE_SUB) ? (v_next - thresh) : '0;
          rcnt  <= refrac;
        end else begin
          v <= v_next;
        end
      end
    end
  end

endmodule

// File: rtl/lif_array.sv
// lif_array: N_CH leaky integrate-and-fire channels with shared configuration.
// Ports:
//   clk, rst                 clock, async active-high reset
//   tick                     one update step for all channels
//   cur_we, cur_ch, cur_val  write port for per-channel input current registers
//   thresh, leak_shift,
//   refrac, sub_mode         shared configuration, sampled on each tick
//   mon_sel, mon_state       membrane monitor (0 for out-of-range channel)
//   spike [N_CH]             registered per-channel spike pulses
//   spike_cnt [16]           saturating total of spikes since reset
module lif_array
  import lif_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int W    = 8,
  parameter int RW   = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                tick,
  input  logic                                cur_we,
  input  logic [(N_CH>1?$clog2(N_CH):1)-1:0] cur_ch,
  input  logic [W-1:0]                        cur_val,
  input  logic [W-1:0]                        thresh,
  input  logic [2:0]                          leak_shift,
  input  logic [RW-1:0]                       refrac,
  input  logic                                sub_mode,
  input  logic [(N_CH>1?$clog2(N_CH):1)-1:0] mon_sel,
  output logic [W-1:0]                        mon_state,
  output logic [N_CH-1:0]                     spike,
  output logic [SPIKE_CNT_W-1:0]              spike_cnt
);

  logic [W-1:0]           cur_reg [N_CH];
  logic [W-1:0]           v_all   [N_CH];
  logic [4:0]             pop;
  logic [SPIKE_CNT_W:0]   cnt_sum;

  // Cells see the pre-edge current, so a write coinciding with a tick
  // only affects the following tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) cur_reg[i] <= '0;
    end else if (cur_we && (int'(cur_ch) < N_CH)) begin
      cur_reg[cur_ch] <= cur_val;
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_cell
    lif_cell #(.W(W), .RW(RW)) u_cell (
      .clk        (clk),
      .rst        (rst),
      .tick       (tick),
      .cur        (cur_reg[g]),
      .thresh     (thresh),
      .leak_shift (leak_shift),
      .refrac     (refrac),
      .sub_mode   (sub_mode),
      .v          (v_all[g]),
      .spike      (spike[g])
    );
  end

  always_comb begin
    mon_state = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (int'(mon_sel) == i) mon_state = v_all[i];
    end
  end

  always_comb begin
    pop = '0;
    for (int i = 0; i < N_CH; i++) pop = pop + 5'(spike[i]);
    cnt_sum = {1'b0, spike_cnt} + (SPIKE_CNT_W+1)'(pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spike_cnt <= '0;
    end else begin
      spike_cnt <= cnt_sum[SPIKE_CNT_W] ? '1 : cnt_sum[SPIKE_CNT_W-1:0];
    end
  end

endmodule

// File: tb/tb_lif_array.sv
module tb_lif_array;

  logic        clk = 1'b0;
  logic        rst;
  logic        tick;
  logic        cur_we;
  logic [1:0]  cur_ch;
  logic [7:0]  cur_val;
  logic [7:0]  thresh;
  logic [2:0]  leak_shift;
  logic [3:0]  refrac;
  logic        sub_mode;
  logic [1:0]  mon_sel;
  logic [7:0]  mon_state;
  logic [3:0]  spike;
  logic [15:0] spike_cnt;

  int checks   = 0;
  int failures = 0;

  lif_array #(.N_CH(4), .W(8), .RW(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .cur_we     (cur_we),
    .cur_ch     (cur_ch),
    .cur_val    (cur_val),
    .thresh     (thresh),
    .leak_shift (leak_shift),
    .refrac     (refrac),
    .sub_mode   (sub_mode),
    .mon_sel    (mon_sel),
    .mon_state  (mon_state),
    .spike      (spike),
    .spike_cnt  (spike_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        t;
    logic        we;
    logic [1:0]  ch;
    logic [7:0]  val;
    logic [7:0]  th;
    logic [2:0]  ls;
    logic [3:0]  rf;
    logic        sm;
    logic [1:0]  ms;
    logic [7:0]  e_mon;
    logic [3:0]  e_spk;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic t, logic we, logic [1:0] ch, logic [7:0] val,
                              logic [7:0] th, logic [2:0] ls, logic [3:0] rf, logic sm,
                              logic [1:0] ms, logic [7:0] e_mon, logic [3:0] e_spk,
                              logic [15:0] e_cnt);
    vec_t r;
    r.t = t; r.we = we; r.ch = ch; r.val = val; r.th = th; r.ls = ls; r.rf = rf;
    r.sm = sm; r.ms = ms; r.e_mon = e_mon; r.e_spk = e_spk; r.e_cnt = e_cnt;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; tick = 0; cur_we = 0; cur_ch = 0; cur_val = 0;
    thresh = 8'd100; leak_shift = 0; refrac = 0; sub_mode = 0; mon_sel = 0;

    // t, we, ch, val, th, ls, rf, sm, ms, e_mon, e_spk, e_cnt
    // integrate-and-fire, I0=30, thresh 100
    vq.push_back(mk(0,1,0, 30,100,0,0,0,0,  0,4'b0000,0));
    vq.push_back(mk(1,0,0,  0,100,0,0,0,0, 30,4'b0000,0));
    vq.push_back(mk(1,0,0,  0,100,0,0,0,0, 60,4'b0000,0));
    vq.push_back(mk(1,0,0,  0,100,0,0,0,0, 90,4'b0000,0));
    vq.push_back(mk(1,0,0,  0,100,0,0,0,0,  0,4'b0001,0));
    vq.push_back(mk(0,0,0,  0,100,0,0,0,0,  0,4'b0000,1));
    vq.push_back(mk(0,1,0,  0,100,0,0,0,0,  0,4'b0000,1));
    // subtract-threshold on ch1, I=70
    vq.push_back(mk(0,1,1, 70,100,0,0,1,1,  0,4'b0000,1));
    vq.push_back(mk(1,0,0,  0,100,0,0,1,1, 70,4'b0000,1));
    vq.push_back(mk(1,0,0,  0,100,0,0,1,1, 40,4'b0010,1));
    vq.push_back(mk(0,0,0,  0,100,0,0,1,1, 40,4'b0000,2));
    vq.push_back(mk(1,0,0,  0,100,0,0,1,1, 10,4'b0010,2));
    vq.push_back(mk(0,0,0,  0,100,0,0,1,1, 10,4'b0000,3));
    vq.push_back(mk(1,0,0,  0,100,0,0,1,1, 80,4'b0000,3));
    vq.push_back(mk(0,1,1,  0,100,0,0,0,1, 80,4'b0000,3));
    // refractory on ch3, refrac=3, I=200
    vq.push_back(mk(0,1,3,200,100,0,3,0,3,  0,4'b0000,3));
    vq.push_back(mk(1,0,0,  0,100,0,3,0,3,  0,4'b1000,3));
    vq.push_back(mk(1,0,0,  0,100,0,3,0,3,  0,4'b0000,4));
    vq.push_back(mk(1,0,0,  0,100,0,3,0,3,  0,4'b0000,4));
    vq.push_back(mk(1,0,0,  0,100,0,3,0,3,  0,4'b0000,4));
    vq.push_back(mk(1,0,0,  0,100,0,3,0,3,  0,4'b1000,4));
    vq.push_back(mk(0,1,3,  0,100,0,0,0,3,  0,4'b0000,5));
    // leak on ch2: preset 64, then halve with I=0
    vq.push_back(mk(0,1,2, 64,100,0,0,0,2,  0,4'b0000,5));
    vq.push_back(mk(1,0,0,  0,100,0,0,0,2, 64,4'b0000,5));
    vq.push_back(mk(0,1,2,  0,100,1,0,0,2, 64,4'b0000,5));
    vq.push_back(mk(1,0,0,  0,100,1,0,0,2, 32,4'b0000,5));
    vq.push_back(mk(1,0,0,  0,100,1,0,0,2, 16,4'b0000,5));
    vq.push_back(mk(1,0,0,  0,100,1,0,0,2,  8,4'b0000,5));
    // write with same-cycle tick uses old I; thresh=0 disables firing, saturation
    vq.push_back(mk(1,1,2,255,  0,0,0,0,2,  8,4'b0000,5));
    vq.push_back(mk(1,0,0,  0,  0,0,0,0,2,255,4'b0000,5));
    vq.push_back(mk(1,0,0,  0,  0,0,0,0,2,255,4'b0000,5));

    #12;
    // reset state
    for (int c = 0; c < 4; c++) begin
      mon_sel = 2'(c); #1;
      chk($sformatf("reset_mon%0d", c), 32'(mon_state), 32'd0);
    end
    chk("reset_spike", 32'(spike), 32'd0);
    chk("reset_cnt", 32'(spike_cnt), 32'd0);
    rst = 1'b0;
    #3;

    foreach (vq[i]) begin
      tick = vq[i].t; cur_we = vq[i].we; cur_ch = vq[i].ch; cur_val = vq[i].val;
      thresh = vq[i].th; leak_shift = vq[i].ls; refrac = vq[i].rf;
      sub_mode = vq[i].sm; mon_sel = vq[i].ms;
      @(posedge clk); #1;
      chk($sformatf("vec%0d_mon", i), 32'(mon_state), 32'(vq[i].e_mon));
      chk($sformatf("vec%0d_spike", i), 32'(spike), 32'(vq[i].e_spk));
      chk($sformatf("vec%0d_cnt", i), 32'(spike_cnt), 32'(vq[i].e_cnt));
    end

    // reset between firing edge and the cycle that would count the spike
    cur_we = 0; thresh = 8'd100; tick = 1;
    @(posedge clk); #1;
    chk("pre_rst_spike", 32'(spike), 32'b0100);
    rst = 1'b1; #2; rst = 1'b0; #1;
    chk("post_rst_spike", 32'(spike), 32'd0);
    chk("post_rst_cnt", 32'(spike_cnt), 32'd0);
    for (int c = 0; c < 4; c++) begin
      mon_sel = 2'(c); #1;
      chk($sformatf("post_rst_mon%0d", c), 32'(mon_state), 32'd0);
    end
    // currents were cleared too: ticking leaves everything at zero
    mon_sel = 2;
    @(posedge clk); #1;
    chk("after_rst_tick_mon", 32'(mon_state), 32'd0);
    chk("after_rst_tick_spike", 32'(spike), 32'd0);
    @(posedge clk); #1;
    chk("after_rst_tick_cnt", 32'(spike_cnt), 32'd0);

    // spike counter saturation: all channels fire every tick
    tick = 0; thresh = 8'd1; refrac = 0; sub_mode = 0;
    for (int c = 0; c < 4; c++) begin
      cur_we = 1; cur_ch = 2'(c); cur_val = 8'd255;
      @(posedge clk); #1;
    end
    cur_we = 0; tick = 1;
    repeat (10) @(posedge clk);
    #1;
    chk("all_fire_spike", 32'(spike), 32'hF);
    chk("all_fire_cnt", 32'(spike_cnt), 32'd36);
    repeat (16400) @(posedge clk);
    #1;
    chk("sat_cnt", 32'(spike_cnt), 32'hFFFF);
    tick = 0;
    @(posedge clk); #1;
    chk("sat_cnt_hold", 32'(spike_cnt), 32'hFFFF);
    chk("idle_spike_clear", 32'(spike), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
